// File: rtl/mem_arbiter.sv
// Two-port byte RAM arbiter: serialises port 0 / port 1 accesses one byte at a time
// with a req/ack handshake per port and registered RAM address, data and write strobe.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [7:0]            p0_wdata_i,
  output logic                  p0_ack_o,
  output logic [7:0]            p0_rdata_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [7:0]            p1_wdata_i,
  output logic                  p1_ack_o,
  output logic [7:0]            p1_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [7:0]            mem_data_in_o,
  output logic                  mem_write_o,
  input  logic [7:0]            mem_data_out_i,
  output logic                  busy_o,
  output logic                  grant_o
);

  localparam int unsigned CntW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LATENCY);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [7:0]            rdata0_q, rdata0_d;
  logic [7:0]            rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  mem_write_q, mem_write_d;

  logic                  pick;
  logic                  pick_we;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [7:0]            pick_wdata;

  // On contention round-robin favours the port that did not win last time.
  always_comb begin
    pick = 1'b0;
    if (p0_req_i && p1_req_i) begin
      pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
    end else begin
      pick = p1_req_i;
    end
    pick_we    = pick ? p1_we_i    : p0_we_i;
    pick_addr  = pick ? p1_addr_i  : p0_addr_i;
    pick_wdata = pick ? p1_wdata_i : p0_wdata_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    grant_d     = grant_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    mem_write_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (p0_req_i || p1_req_i) begin
          sel_d   = pick;
          grant_d = pick;
          last_d  = pick;
          if (pick_we) begin
            state_d     = StWrite;
            waddr_d     = pick_addr;
            wdata_d     = pick_wdata;
            mem_write_d = 1'b1;
          end else begin
            state_d = StRead;
            raddr_d = pick_addr;
            cnt_d   = '0;
          end
        end
      end
      StWrite: begin
        state_d = StDone;
        ack0_d  = ~sel_q;
        ack1_d  = sel_q;
      end
      StRead: begin
        // RAM output is valid in the last read cycle; capture it for the granted port.
        if (cnt_q == CntLast) begin
          state_d = StDone;
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          if (sel_q) begin
            rdata1_d = mem_data_out_i;
          end else begin
            rdata0_d = mem_data_out_i;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign p0_ack_o      = ack0_q;
  assign p1_ack_o      = ack1_q;
  assign p0_rdata_o    = rdata0_q;
  assign p1_rdata_o    = rdata1_q;
  assign mem_raddr_o   = raddr_q;
  assign mem_waddr_o   = waddr_q;
  assign mem_data_in_o = wdata_q;
  assign mem_write_o   = mem_write_q;
  assign busy_o        = (state_q != StIdle);
  assign grant_o       = grant_q;

endmodule
